// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester ports A/B plus memory bus of the data-memory arbiter.
// err exists only when DMEM_ADDR_CHECK_EN is defined.
interface dmem_arbiter_if #(parameter int AW = 8, parameter int DW = 8);
  logic a_req, b_req, a_we, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic a_gnt, b_gnt, a_done, b_done;
  logic [DW-1:0] a_rdata, b_rdata;
  logic [AW-1:0] address;
  logic [DW-1:0] write_data;
  logic memwrite, memread;
  logic [DW-1:0] read_data;
`ifdef DMEM_ADDR_CHECK_EN
  logic err;
`endif
  modport master (
`ifdef DMEM_ADDR_CHECK_EN
    input err,
`endif
    output a_req, b_req, a_we, b_we, a_addr, b_addr, a_wdata, b_wdata, read_data,
    input a_gnt, b_gnt, a_done, b_done, a_rdata, b_rdata, address, write_data, memwrite, memread
  );
  modport slave (
`ifdef DMEM_ADDR_CHECK_EN
    output err,
`endif
    input a_req, b_req, a_we, b_we, a_addr, b_addr, a_wdata, b_wdata, read_data,
    output a_gnt, b_gnt, a_done, b_done, a_rdata, b_rdata, address, write_data, memwrite, memread
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port (A=CPU, B=DMA) arbiter, IDLE->ACCESS->DONE per access.
// Optional macro DMEM_ADDR_CHECK_EN: addresses >= MEM_DEPTH skip memory, return 0 and pulse err.
module dmem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8,
  parameter int MEM_DEPTH = 64
) (
  input logic clk,
  input logic reset,
  dmem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state;
  logic last_b, win_q, we_q, oob_q, win_b, sel_we, oob;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata, rd;
  // B wins alone, or on a tie when A won last
  assign win_b = bus.b_req & (~bus.a_req | ~last_b);
  assign sel_we = win_b ? bus.b_we : bus.a_we;
  assign sel_addr = win_b ? bus.b_addr : bus.a_addr;
  assign sel_wdata = win_b ? bus.b_wdata : bus.a_wdata;
  assign rd = oob_q ? '0 : bus.read_data;
`ifdef DMEM_ADDR_CHECK_EN
  assign oob = 32'(sel_addr) >= MEM_DEPTH;
`else
  assign oob = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last_b <= 1'b1;
      win_q <= 1'b0;
      we_q <= 1'b0;
      oob_q <= 1'b0;
      bus.a_gnt <= 1'b0;
      bus.b_gnt <= 1'b0;
      bus.a_done <= 1'b0;
      bus.b_done <= 1'b0;
      bus.memwrite <= 1'b0;
      bus.memread <= 1'b0;
      bus.address <= '0;
      bus.write_data <= '0;
      bus.a_rdata <= '0;
      bus.b_rdata <= '0;
`ifdef DMEM_ADDR_CHECK_EN
      bus.err <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (bus.a_req | bus.b_req) begin
          state <= ACCESS;
          win_q <= win_b;
          we_q <= sel_we;
          oob_q <= oob;
          last_b <= win_b;
          bus.a_gnt <= ~win_b;
          bus.b_gnt <= win_b;
          bus.address <= sel_addr;
          bus.write_data <= sel_wdata;
          bus.memwrite <= sel_we & ~oob;
          bus.memread <= ~sel_we & ~oob;
        end
        ACCESS: begin
          state <= DONE;
          bus.a_gnt <= 1'b0;
          bus.b_gnt <= 1'b0;
          bus.memwrite <= 1'b0;
          bus.memread <= 1'b0;
          bus.a_done <= ~win_q;
          bus.b_done <= win_q;
          if (!we_q || oob_q) begin
            if (win_q) bus.b_rdata <= rd;
            else bus.a_rdata <= rd;
          end
`ifdef DMEM_ADDR_CHECK_EN
          bus.err <= oob_q;
`endif
        end
        default: begin
          state <= IDLE;
          bus.a_done <= 1'b0;
          bus.b_done <= 1'b0;
`ifdef DMEM_ADDR_CHECK_EN
          bus.err <= 1'b0;
`endif
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench with a behavioural memory (mem[i]=i on reset).
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;
  logic [7:0] mem [256];
  dmem_arbiter_if #(.AW(8), .DW(8)) bus();
  dmem_arbiter #(.AW(8), .DW(8), .MEM_DEPTH(64)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  assign bus.read_data = mem[bus.address];
  always @(posedge clk) begin
    if (reset) for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
    else if (bus.memwrite) mem[bus.address] <= bus.write_data;
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    reset = 1'b1;
    {bus.a_req, bus.b_req, bus.a_we, bus.b_we} = '0;
    {bus.a_addr, bus.b_addr, bus.a_wdata, bus.b_wdata} = '0;
    step();
    step();
    chk("rst_gnt", {bus.a_gnt, bus.b_gnt}, 0);
    chk("rst_done", {bus.a_done, bus.b_done}, 0);
    chk("rst_strobes", {bus.memwrite, bus.memread}, 0);
    chk("rst_bus", {bus.address, bus.write_data}, 0);
    chk("rst_rdata", {bus.a_rdata, bus.b_rdata}, 0);
    reset = 1'b0;
    // A write 0xAA to 0x05
    bus.a_req = 1; bus.a_we = 1; bus.a_addr = 8'h05; bus.a_wdata = 8'hAA;
    step();
    chk("w_gnt", {bus.a_gnt, bus.b_gnt}, 2'b10);
    chk("w_strobes", {bus.memwrite, bus.memread}, 2'b10);
    chk("w_bus", {bus.address, bus.write_data}, 16'h05AA);
    chk("w_nodone_yet", bus.a_done, 0);
    step();
    chk("w_done", {bus.a_done, bus.b_done}, 2'b10);
    chk("w_strobe_off", {bus.memwrite, bus.a_gnt}, 0);
    bus.a_req = 0;
    step();
    chk("w_done_one_cycle", bus.a_done, 0);
    // A read back 0x05
    bus.a_req = 1; bus.a_we = 0;
    step();
    chk("r_strobes", {bus.memwrite, bus.memread}, 2'b01);
    step();
    chk("r_done", bus.a_done, 1);
    chk("r_rdata", bus.a_rdata, 8'hAA);
    bus.a_req = 0;
    step();
    // tie after reset: A, B, A
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst2_rdata", bus.a_rdata, 0);
    bus.a_req = 1; bus.a_we = 0; bus.a_addr = 8'h01;
    bus.b_req = 1; bus.b_we = 0; bus.b_addr = 8'h02;
    step();
    chk("rr1_gnt", {bus.a_gnt, bus.b_gnt}, 2'b10);
    step();
    chk("rr1_done", {bus.a_done, bus.b_done}, 2'b10);
    chk("rr1_rdata", bus.a_rdata, 8'h01);
    step();
    chk("rr_idle", {bus.a_gnt, bus.b_gnt, bus.a_done, bus.b_done}, 0);
    step();
    chk("rr2_gnt", {bus.a_gnt, bus.b_gnt}, 2'b01);
    chk("rr2_bus", bus.address, 8'h02);
    step();
    chk("rr2_done", {bus.a_done, bus.b_done}, 2'b01);
    chk("rr2_rdata", bus.b_rdata, 8'h02);
    step();
    step();
    chk("rr3_gnt", {bus.a_gnt, bus.b_gnt}, 2'b10);
    step();
    chk("rr3_done", {bus.a_done, bus.b_done}, 2'b10);
    bus.a_req = 0; bus.b_req = 0;
    step();
    // B read 0x10 alone
    bus.b_req = 1; bus.b_we = 0; bus.b_addr = 8'h10;
    step();
    chk("b_gnt", {bus.a_gnt, bus.b_gnt}, 2'b01);
    chk("b_strobes", {bus.memwrite, bus.memread}, 2'b01);
    chk("b_addr", bus.address, 8'h10);
    step();
    chk("b_done", {bus.a_done, bus.b_done}, 2'b01);
    chk("b_rdata", bus.b_rdata, 8'h10);
    chk("b_a_rdata_held", bus.a_rdata, 8'h01);
    chk("b_no_agnt", bus.a_gnt, 0);
    bus.b_req = 0;
    step();
    // reset during ACCESS of write 0x3F to 0x01
    bus.a_req = 1; bus.a_we = 1; bus.a_addr = 8'h01; bus.a_wdata = 8'h3F;
    step();
    chk("ab_memwrite", bus.memwrite, 1);
    reset = 1'b1; bus.a_req = 0;
    step();
    chk("ab_done", {bus.a_done, bus.b_done}, 0);
    chk("ab_strobes", {bus.memwrite, bus.memread, bus.a_gnt}, 0);
    chk("ab_bus", {bus.address, bus.write_data}, 0);
    reset = 1'b0;
    step();
    chk("ab_idle", {bus.a_gnt, bus.a_done, bus.a_rdata}, 0);
    // valid read, then address 0x40 write and read
    bus.a_req = 1; bus.a_we = 0; bus.a_addr = 8'h03;
    step();
    step();
    chk("v_rdata", bus.a_rdata, 8'h03);
`ifdef DMEM_ADDR_CHECK_EN
    chk("v_err", bus.err, 0);
`endif
    bus.a_req = 0;
    step();
    bus.a_req = 1; bus.a_we = 1; bus.a_addr = 8'h40; bus.a_wdata = 8'h55;
    step();
    chk("o_gnt", bus.a_gnt, 1);
`ifdef DMEM_ADDR_CHECK_EN
    chk("o_w_strobes", {bus.memwrite, bus.memread}, 0);
    step();
    chk("o_w_done_err", {bus.a_done, bus.err}, 2'b11);
`else
    chk("o_w_strobes", {bus.memwrite, bus.memread}, 2'b10);
    step();
    chk("o_w_done", bus.a_done, 1);
`endif
    bus.a_req = 0;
    step();
    bus.a_req = 1; bus.a_we = 0;
    step();
`ifdef DMEM_ADDR_CHECK_EN
    chk("o_r_strobes", {bus.memwrite, bus.memread}, 0);
    step();
    chk("o_r_done_err", {bus.a_done, bus.err}, 2'b11);
    chk("o_r_rdata", bus.a_rdata, 0);
    bus.a_req = 0;
    step();
    chk("o_err_one_cycle", bus.err, 0);
`else
    chk("o_r_strobes", {bus.memwrite, bus.memread}, 2'b01);
    step();
    chk("o_r_done", bus.a_done, 1);
    chk("o_r_rdata", bus.a_rdata, 8'h55);
    bus.a_req = 0;
    step();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 8, meaning the address width in bits.
REQ-002 The block SHALL have parameter DW, default 8, meaning the data width in bits.
REQ-003 The block SHALL have parameter MEM_DEPTH, default 64, meaning the number of implemented data-memory words.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have ports a_req / b_req, input, 1 bit each: access request from port A (CPU) / port B (DMA).
REQ-007 The block SHALL have ports a_we / b_we, input, 1 bit each: 1 = write, 0 = read.
REQ-008 The block SHALL have ports a_addr / b_addr, input, AW bits each: word address.
REQ-009 The block SHALL have ports a_wdata / b_wdata, input, DW bits each: write data.
REQ-010 The block SHALL have ports a_gnt / b_gnt, output, 1 bit each: high during that port's ACCESS cycle.
REQ-011 The block SHALL have ports a_done / b_done, output, 1 bit each: one-cycle completion pulse.
REQ-012 The block SHALL have ports a_rdata / b_rdata, output, DW bits each: registered read data, valid when done is high after a read.
REQ-013 The block SHALL have port address, output, AW bits: memory address.
REQ-014 The block SHALL have port write_data, output, DW bits: memory write data.
REQ-015 The block SHALL have ports memwrite / memread, output, 1 bit each: memory strobes.
REQ-016 The block SHALL have port read_data, input, DW bits: combinational memory read data.

Function
REQ-017 The FSM SHALL have states IDLE, ACCESS and DONE, with transitions IDLE->ACCESS when any req is sampled high, ACCESS->DONE unconditionally, and DONE->IDLE unconditionally.
REQ-018 In IDLE, the winner SHALL be the sole requester, or on a tie the port other than last_winner (round-robin); the winner, we, addr and wdata SHALL be latched.
REQ-019 In ACCESS, only the winner's gnt SHALL be high, and address/write_data SHALL be driven from the latched values.
REQ-020 In ACCESS, memwrite = latched we and memread = not latched we; both SHALL be 0 in every other state.
REQ-021 A read SHALL capture read_data into the winner's rdata register at the end of ACCESS; the non-winner's rdata SHALL hold its previous value.
REQ-022 In DONE, the winner's done SHALL pulse for one cycle, giving latency from req sampled to done of 2 cycles and 3 cycles per access.
REQ-023 Requesters SHALL hold req, we, addr and wdata stable until done; req high in the IDLE following DONE SHALL be treated as a new request.
REQ-024 last_winner SHALL update on the IDLE->ACCESS transition; continuous requests from both ports SHALL alternate A,B,A,B.
REQ-025 A req that rises while the FSM is in ACCESS or DONE SHALL wait for the next IDLE.

Reset
REQ-026 Reset SHALL force state to IDLE, last_winner to B (so A wins the first tie), and gnt, done, memwrite, memread, address, write_data and rdata to 0.
REQ-027 Reset asserted during ACCESS SHALL abort the access: no done pulse, no rdata update, and memwrite is 0 from the following cycle.

Configuration
REQ-028 With macro DMEM_ADDR_CHECK_EN defined, a latched address >= MEM_DEPTH SHALL suppress memwrite and memread in ACCESS, load 0 into the winner's rdata, and still pulse done; output err, 1 bit, SHALL pulse with that done.
REQ-029 Without DMEM_ADDR_CHECK_EN, the err port SHALL NOT exist and all addresses SHALL pass to memory unchecked.

Verification
REQ-030 The bench SHALL cover: A write addr 0x05 data 0xAA, then A read 0x05 -> memwrite one cycle, a_done 2 cycles after req, a_rdata = 0xAA.
REQ-031 The bench SHALL cover: a_req and b_req rise together after reset, both held -> grant order A, B, A; done pulses every 3 cycles.
REQ-032 The bench SHALL cover: B read addr 0x10 of memory initialised mem[i]=i -> b_rdata = 0x10, a_rdata unchanged, a_gnt never high.
REQ-033 The bench SHALL cover: reset asserted during an ACCESS write of 0x3F to addr 0x01 -> no done, state IDLE next cycle, outputs 0.
REQ-034 The bench SHALL cover: with DMEM_ADDR_CHECK_EN, A write addr 0x40 -> memwrite stays 0, err and a_done pulse together, rdata 0 on a read.
